// File: rtl/csa_pkg.sv
// Shared definitions for the CSA programmable S-box: default S7 contents,
// default-entry helper and the init/run FSM state type.
package csa_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // S7 mapping, entry i at bits [2i+1:2i]
  localparam logic [63:0] S7_DEFAULT = 64'h8E1E_94F1_69D3_43AC;

  // Default entry for table index idx: S7[idx mod 32], zero-extended,
  // or reduced to its low bit when the table is only one bit wide.
  function automatic logic [31:0] s7_entry(input int unsigned idx, input int unsigned out_w);
    logic [5:0] bitpos;
    logic [1:0] raw;
    bitpos = 6'((idx % 32) * 2);
    raw    = S7_DEFAULT[bitpos +: 2];
    if (out_w < 2) s7_entry = {31'd0, raw[0]};
    else           s7_entry = {30'd0, raw};
  endfunction

endpackage

// File: rtl/csa_sbox_prog_if.sv
// Configuration and lookup bus of the programmable S-box.
interface csa_sbox_prog_if #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 2,
  parameter int LANES = 1
);
  logic                   busy;
  logic                   cfg_we;
  logic [IN_W-1:0]        cfg_addr;
  logic [OUT_W-1:0]       cfg_data;
  logic                   cfg_err;
  logic                   in_valid;
  logic [LANES*IN_W-1:0]  in;
  logic                   out_valid;
  logic [LANES*OUT_W-1:0] out;

  modport master (
    output cfg_we, cfg_addr, cfg_data, in_valid, in,
    input  busy, cfg_err, out_valid, out
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, in_valid, in,
    output busy, cfg_err, out_valid, out
  );
endinterface

// File: rtl/csa_sbox_prog.sv
// Programmable multi-lane S-box: a flop table loaded with S7 after reset,
// rewritable at runtime, serving LANES registered lookups per cycle.
module csa_sbox_prog #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 2,
  parameter int LANES = 1
) (
  input logic           clk,
  input logic           rst,
  csa_sbox_prog_if.slave bus
);
  import csa_pkg::*;

  localparam int DEPTH = 2 ** IN_W;

  state_t                 state_q, state_d;
  logic [IN_W-1:0]        cnt_q, cnt_d;
  logic [OUT_W-1:0]       table_q [DEPTH];
  logic                   tbl_we;
  logic [IN_W-1:0]        tbl_addr;
  logic [OUT_W-1:0]       tbl_data;
  logic [31:0]            dflt;
  logic [LANES*OUT_W-1:0] lookup;
  logic [LANES*OUT_W-1:0] out_q;
  logic                   out_valid_q;
  logic                   cfg_err_q;
  logic                   run;

  assign run = (state_q == RUN);

  // FSM state and init counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and table write-port mux: init loader in INIT, cfg port in RUN
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dflt     = s7_entry(32'(cnt_q), OUT_W);
    tbl_we   = 1'b0;
    tbl_addr = cnt_q;
    tbl_data = dflt[OUT_W-1:0];
    if (state_q == INIT) begin
      tbl_we = ~rst;
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == {IN_W{1'b1}}) state_d = RUN;
    end else begin
      tbl_we   = bus.cfg_we & ~rst;
      tbl_addr = bus.cfg_addr;
      tbl_data = bus.cfg_data;
    end
  end

  // Table storage; no reset needed because INIT rewrites every entry
  always_ff @(posedge clk) begin
    if (tbl_we) table_q[tbl_addr] <= tbl_data;
  end

  // Per-lane read of the pre-write table contents
  always_comb begin
    lookup = '0;
    for (int k = 0; k < LANES; k++) begin
      lookup[k*OUT_W +: OUT_W] = table_q[bus.in[k*IN_W +: IN_W]];
    end
  end

  // Result register, valid flag and dropped-write pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      out_valid_q <= run & bus.in_valid;
      cfg_err_q   <= ~run & bus.cfg_we;
      if (run & bus.in_valid) out_q <= lookup;
    end
  end

  assign bus.busy      = ~run;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_csa_sbox_prog.sv
// Bench for csa_sbox_prog: a default 1-lane instance and a 4-lane/6-bit/3-bit
// instance, each followed every cycle by a behavioural table model.
module tb_csa_sbox_prog;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csa_sbox_prog_if #(.IN_W(5), .OUT_W(2), .LANES(1)) ifa ();
  csa_sbox_prog_if #(.IN_W(6), .OUT_W(3), .LANES(4)) ifb ();

  csa_sbox_prog #(.IN_W(5), .OUT_W(2), .LANES(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  csa_sbox_prog #(.IN_W(6), .OUT_W(3), .LANES(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  int n_chk  = 0;
  int n_fail = 0;
  int s7 [32] = '{0,3,2,2,3,0,0,1,3,0,1,3,1,2,2,1,1,0,3,3,0,1,1,2,2,3,1,0,2,3,0,2};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: after reset the table holds the defaults, the first
  // 2^IN_W edges are initialisation, then lookups see the pre-write table.
  logic [1:0]  ma_tab [32];
  int          ma_left, mb_left;
  logic        ma_busy, ma_ov, ma_err, mb_busy, mb_ov;
  logic [1:0]  ma_out;
  logic [11:0] mb_out;
  bit          model_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) ma_tab[i] = 2'(s7[i]);
      ma_left = 32; ma_busy = 1'b1; ma_ov = 1'b0; ma_out = '0; ma_err = 1'b0;
      mb_left = 64; mb_busy = 1'b1; mb_ov = 1'b0; mb_out = '0;
      model_on = 1'b1;
    end else if (model_on) begin
      if (ma_left > 0) begin
        ma_err = ifa.cfg_we;
        ma_ov  = 1'b0;
        ma_left--;
      end else begin
        ma_err = 1'b0;
        ma_ov  = ifa.in_valid;
        if (ifa.in_valid) ma_out = ma_tab[ifa.in];
        if (ifa.cfg_we) ma_tab[ifa.cfg_addr] = ifa.cfg_data;
      end
      ma_busy = (ma_left > 0);
      if (mb_left > 0) begin
        mb_ov = 1'b0;
        mb_left--;
      end else begin
        mb_ov = ifb.in_valid;
        if (ifb.in_valid)
          for (int k = 0; k < 4; k++) mb_out[k*3 +: 3] = 3'(s7[ifb.in[k*6 +: 6] % 32]);
      end
      mb_busy = (mb_left > 0);
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (model_on) begin
      check("a_busy", ifa.busy, ma_busy);
      check("a_out_valid", ifa.out_valid, ma_ov);
      check("a_cfg_err", ifa.cfg_err, ma_err);
      check("a_out", ifa.out, ma_out);
      check("b_busy", ifb.busy, mb_busy);
      check("b_out_valid", ifb.out_valid, mb_ov);
      check("b_cfg_err", ifb.cfg_err, 1'b0);
      check("b_out", ifb.out, mb_out);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic lookup_a(input logic [4:0] idx);
    ifa.in_valid = 1'b1;
    ifa.in       = idx;
    step();
    ifa.in_valid = 1'b0;
  endtask

  initial begin
    int n, na, nb;
    ifa.cfg_we = 1'b0; ifa.cfg_addr = '0; ifa.cfg_data = '0; ifa.in_valid = 1'b0; ifa.in = '0;
    ifb.cfg_we = 1'b0; ifb.cfg_addr = '0; ifb.cfg_data = '0; ifb.in_valid = 1'b0; ifb.in = '0;
    rst = 1'b1;
    repeat (3) step();
    check("rst_busy", ifa.busy, 1);
    check("rst_out_valid", ifa.out_valid, 0);
    check("rst_out", ifa.out, 0);
    check("rst_cfg_err", ifa.cfg_err, 0);

    // Initialisation length of both instances
    rst = 1'b0;
    n = 0; na = 0; nb = 0;
    while ((ifa.busy || ifb.busy) && n < 200) begin
      step();
      n++;
      if (!ifa.busy && na == 0) na = n;
      if (!ifb.busy && nb == 0) nb = n;
    end
    check("a_init_len", na, 32);
    check("b_init_len", nb, 64);

    // Full sweep of the default table
    for (int i = 0; i < 32; i++) begin
      lookup_a(5'(i));
      check("sweep", ifa.out, s7[i]);
    end
    lookup_a(5'h0B);
    check("lookup_0B", ifa.out, 3);
    lookup_a(5'h1F);
    check("lookup_1F", ifa.out, 2);
    check("lookup_valid", ifa.out_valid, 1);

    // Runtime write, neighbour untouched
    ifa.cfg_we = 1'b1; ifa.cfg_addr = 5'h05; ifa.cfg_data = 2'd3;
    step();
    ifa.cfg_we = 1'b0;
    lookup_a(5'h05);
    check("write_05", ifa.out, 3);
    lookup_a(5'h06);
    check("neigh_06", ifa.out, 0);

    // Write and lookup of the same index in one cycle
    ifa.cfg_we = 1'b1; ifa.cfg_addr = 5'h0D; ifa.cfg_data = 2'd0;
    ifa.in_valid = 1'b1; ifa.in = 5'h0D;
    step();
    ifa.cfg_we = 1'b0;
    check("same_cycle_old", ifa.out, 2);
    step();
    ifa.in_valid = 1'b0;
    check("same_cycle_new", ifa.out, 0);

    // Four lanes, repeated index
    ifb.in = {6'h21, 6'h3F, 6'h21, 6'h00};
    ifb.in_valid = 1'b1;
    step();
    ifb.in_valid = 1'b0;
    check("b_lanes", ifb.out, {3'd3, 3'd2, 3'd3, 3'd0});
    check("b_lanes_valid", ifb.out_valid, 1);

    // Random traffic with occasional reset pulses
    for (int r = 0; r < 400; r++) begin
      rst          = ($urandom_range(0, 99) == 0);
      ifa.cfg_we   = ($urandom_range(0, 3) == 0);
      ifa.cfg_addr = 5'($urandom);
      ifa.cfg_data = 2'($urandom);
      ifa.in_valid = 1'($urandom);
      ifa.in       = 5'($urandom);
      ifb.in_valid = 1'($urandom);
      ifb.in       = 24'($urandom);
      step();
    end
    rst = 1'b0; ifa.cfg_we = 1'b0; ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    n = 0;
    while ((ifa.busy || ifb.busy) && n < 200) begin
      step();
      n++;
    end
    check("settle_busy", ifa.busy, 0);

    // Reset in RUN after reprogramming, with a lookup in flight
    ifa.cfg_we = 1'b1; ifa.cfg_addr = 5'h01; ifa.cfg_data = 2'd0;
    step();
    ifa.cfg_we = 1'b0;
    ifa.in_valid = 1'b1; ifa.in = 5'h01;
    rst = 1'b1;
    step();
    check("midrst_out_valid", ifa.out_valid, 0);
    check("midrst_busy", ifa.busy, 1);
    check("midrst_out", ifa.out, 0);
    rst = 1'b0;
    ifa.in_valid = 1'b0;

    // Dropped write at the 10th initialisation cycle
    repeat (9) step();
    ifa.cfg_we = 1'b1; ifa.cfg_addr = 5'h0A; ifa.cfg_data = 2'd2;
    step();
    ifa.cfg_we = 1'b0;
    check("init_cfg_err", ifa.cfg_err, 1);
    step();
    check("init_cfg_err_once", ifa.cfg_err, 0);
    n = 11;
    while (ifa.busy && n < 200) begin
      step();
      n++;
    end
    check("reinit_len", n, 32);
    lookup_a(5'h01);
    check("reinit_01", ifa.out, 3);
    lookup_a(5'h0A);
    check("dropped_0A", ifa.out, 1);

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/csa_sbox_prog.md
# csa_sbox_prog

Programmable, multi-lane S-box lookup unit for the CSA stream-cipher datapath. It generalises the fixed 5-in/2-out S7 combinational mapping into a parametrised, register-backed table. Reset loads the S7 contents; software can rewrite the table at runtime. The unit serves LANES parallel lookups per cycle with a one-cycle registered latency and sits between the stream-cipher state registers and the feedback/output combiner.

## Interface
Parameters:
- IN_W, 5: lookup index width; the table holds 2^IN_W entries.
- OUT_W, 2: entry width.
- LANES, 1: number of parallel lookup lanes sharing one table.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- busy  out  1  high while the default table is being loaded.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  IN_W  write index.
- cfg_data  in  OUT_W  write value.
- cfg_err  out  1  one-cycle pulse when a write is dropped.
- in_valid  in  1  lookup request, applies to all lanes.
- in  in  LANES*IN_W  lane k index is in[k*IN_W +: IN_W].
- out_valid  out  1  lookup result valid.
- out  out  LANES*OUT_W  lane k result is out[k*OUT_W +: OUT_W].

## Operation
- Default S7 sequence for indices 0..31: 0,3,2,2,3,0,0,1,3,0,1,3,1,2,2,1,1,0,3,3,0,1,1,2,2,3,1,0,2,3,0,2.
- Default entry i = S7[i mod 32], zero-extended to OUT_W, or truncated to its low OUT_W bits if OUT_W < 2.
- FSM states: INIT and RUN.
  - rst forces INIT with init counter 0.
  - INIT writes one default entry per cycle, at the counter address, then increments the counter.
  - After writing entry 2^IN_W−1, the FSM moves to RUN. The counter wraps to 0 but is unused in RUN.
  - RUN is terminal until the next rst.
- busy is 1 in INIT and 0 in RUN.
- Lookups:
  - In RUN, when in_valid=1, each lane reads table[in lane index] and registers the result.
  - Lookups in INIT are discarded (out_valid stays 0).
- Writes:
  - In RUN, cfg_we=1 writes cfg_data at cfg_addr.
  - In INIT, cfg_we=1 is dropped, the table is unchanged, and cfg_err pulses the next cycle.
- Simultaneous write and lookup to the same index in one cycle: the lookup returns the old value; the new value is visible from the next cycle.
- Multiple lanes may present the same index in one cycle; each receives the same value.
- A rst asserted mid-operation (during INIT or RUN) discards any in-flight lookup and restarts INIT from entry 0. Any runtime programming is lost.

## Timing
- Reset values, held while rst=1: busy=1, out_valid=0, out=0, cfg_err=0.
- INIT duration: the first edge with rst=0 writes entry 0. Edge number 2^IN_W writes the last entry and enters RUN. busy reads 0 after that edge, i.e. 32 cycles with the default IN_W.
- Lookup latency is 1 cycle: a request sampled at edge n gives out_valid=1 and data after edge n.
- out keeps its last value when out_valid=0; out is cleared only by rst.
- Throughput is one lookup per lane per cycle, with no backpressure.
- cfg_err rises for exactly the one cycle after the edge that sampled the dropped write.

## Structure
- The shared package csa_pkg holds:
  - the S7 default constant, 64-bit packed with entry i at bits [2i+1:2i];
  - a function returning default entry i for a given OUT_W;
  - the FSM state typedef (INIT, RUN).
- No sub-module is needed. The table is a flop array written by either the init FSM or the cfg port, through a mux selected by state.

## Test plan
- Reset, then wait for busy to fall. Check busy falls exactly 32 edges after rst deasserts. Sweep in = 0..31 (LANES=1) and check out matches the S7 sequence, e.g. 0x0B -> 3 and 0x1F -> 2, each one cycle later.
- In RUN, write cfg_addr=0x05, cfg_data=3, then look up 0x05 -> 3. Look up 0x06 -> 0, which must be unchanged.
- In the same cycle, write 0x0D=0 and look up 0x0D. The response is 2 (old value). The next lookup of 0x0D gives 0.
- Assert cfg_we at the 10th cycle of INIT. Check cfg_err pulses once, and that after INIT the addressed entry still holds its S7 default.
- Assert rst for one cycle in RUN, after reprogramming 0x01=0 and with a lookup in flight. Check out_valid=0 and busy=1 on the next cycle, and that after re-init the lookup of 0x01 gives 3.
- Configure LANES=4, IN_W=6, OUT_W=3. Present lanes {0x00, 0x21, 0x3F, 0x21}. Check the results are {0, 3, 2, 3}, and that busy lasts 64 cycles.
